// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between bus sources and the round-robin arbiter
interface bus_arbiter_if #(
  parameter int N     = 24,
  parameter int SEL_W = 5
);
  logic [N-1:0]     req;
  logic             lock;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] bus_sel;
  logic             bus_valid;
  logic             preempt;

  modport master (
    output req, lock,
    input  gnt, bus_sel, bus_valid, preempt
  );

  modport slave (
    input  req, lock,
    output gnt, bus_sel, bus_valid, preempt
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin internal-bus arbiter with dead turnaround and hold-time preemption
module bus_arbiter #(
  parameter int N        = 24,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 8
) (
  input logic          clock,
  input logic          clear,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  localparam logic [7:0]     HOLD_LIM = 8'(MAX_HOLD - 1);
  localparam logic [N-1:0]   ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SEL_W:0] N_EXT    = (SEL_W+1)'(N);

  state_t           r_state;
  logic [SEL_W-1:0] r_last;
  logic [7:0]       r_hold_cnt;
  logic [N-1:0]     r_gnt;
  logic [SEL_W-1:0] r_bus_sel;
  logic             r_bus_valid;
  logic             r_preempt;

  logic [SEL_W-1:0] w_winner;
  logic             w_any_req;
  logic             w_owner_req;
  logic             w_contend;

  // Walk from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    w_winner = '0;
    for (int k = N; k >= 1; k--) begin
      logic [SEL_W:0] w_idx;
      w_idx = {1'b0, r_last} + (SEL_W+1)'(k);
      if (w_idx >= N_EXT) begin
        w_idx = w_idx - N_EXT;
      end
      if (bus.req[w_idx[SEL_W-1:0]]) begin
        w_winner = w_idx[SEL_W-1:0];
      end
    end
  end

  assign w_any_req   = |bus.req;
  assign w_owner_req = |(bus.req & r_gnt);
  assign w_contend   = |(bus.req & ~r_gnt);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state     <= IDLE;
      r_last      <= SEL_W'(N - 1);
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_bus_sel   <= '0;
      r_bus_valid <= 1'b0;
      r_preempt   <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE, TURN: begin
          if (w_any_req) begin
            r_state     <= OWN;
            r_gnt       <= ONE_HOT0 << w_winner;
            r_bus_sel   <= w_winner;
            r_bus_valid <= 1'b1;
            r_last      <= w_winner;
            r_hold_cnt  <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        OWN: begin
          if (r_hold_cnt != 8'hFF) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
          // >= so a lock released late still preempts on the next edge.
          if (!w_owner_req ||
              (r_hold_cnt >= HOLD_LIM && w_contend && !bus.lock)) begin
            r_state     <= TURN;
            r_gnt       <= '0;
            r_bus_sel   <= '0;
            r_bus_valid <= 1'b0;
            r_preempt   <= w_owner_req;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_gnt       <= '0;
          r_bus_sel   <= '0;
          r_bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.bus_sel   = r_bus_sel;
  assign bus.bus_valid = r_bus_valid;
  assign bus.preempt   = r_preempt;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and random checks of bus_arbiter with MAX_HOLD=4
module tb_bus_arbiter;
  localparam int N     = 24;
  localparam int SEL_W = 5;

  logic clock;
  logic clear;
  int   n_checks;
  int   n_fail;

  bus_arbiter_if #(.N(N), .SEL_W(SEL_W)) bus ();

  bus_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    step();
    clear = 1'b1;
  endtask

  task automatic check_owner(input string tag, input int o);
    check({tag, "_sel"}, 32'(bus.bus_sel), 32'(o));
    check({tag, "_gnt"}, 32'(bus.gnt), 32'(1) << o);
    check({tag, "_valid"}, 32'(bus.bus_valid), 32'd1);
  endtask

  task automatic check_idle(input string tag, input logic exp_pre);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    check({tag, "_sel"}, 32'(bus.bus_sel), 32'd0);
    check({tag, "_valid"}, 32'(bus.bus_valid), 32'd0);
    check({tag, "_preempt"}, 32'(bus.preempt), 32'(exp_pre));
  endtask

  int rr_order [4] = '{3, 5, 21, 3};
  logic [N-1:0] prev_gnt;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.req  = '0;
    bus.lock = 1'b0;
    clear    = 1'b0;
    #2;
    check_idle("reset", 1'b0);
    step();
    clear = 1'b1;

    // single request from PC, then release through TURN to IDLE
    bus.req = N'(1) << 20;
    step();
    check_owner("pc_grant", 20);
    bus.req = '0;
    step();
    check_idle("pc_turn", 1'b0);
    step();
    check_idle("pc_idle", 1'b0);

    // round-robin with continuous contention
    do_reset();
    bus.req = (N'(1) << 3) | (N'(1) << 5) | (N'(1) << 21);
    step();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        check_owner($sformatf("rr%0d_c%0d", i, c), rr_order[i]);
        check("rr_no_preempt", 32'(bus.preempt), 32'd0);
        step();
      end
      check_idle($sformatf("rr%0d_turn", i), 1'b1);
      step();
    end

    // wrap: last = 23, then requests on 2 and 22
    bus.req = '0;
    do_reset();
    bus.req = N'(1) << 23;
    step();
    check_owner("wrap_c", 23);
    bus.req = (N'(1) << 2) | (N'(1) << 22);
    step();
    check_idle("wrap_turn", 1'b0);
    step();
    check_owner("wrap_next", 2);

    // lock blocks preemption; dropping it preempts on the next edge
    bus.req = '0;
    do_reset();
    bus.req = N'(1) << 18;
    step();
    check_owner("lock_own", 18);
    bus.lock = 1'b1;
    bus.req  = (N'(1) << 18) | (N'(1) << 1);
    for (int c = 0; c < 20; c++) begin
      step();
      check_owner($sformatf("lock_hold%0d", c), 18);
    end
    bus.lock = 1'b0;
    step();
    check_idle("lock_turn", 1'b1);
    step();
    check_owner("lock_next", 1);

    // asynchronous reset mid-ownership
    #2;
    clear = 1'b0;
    #1;
    check("areset_gnt", 32'(bus.gnt), 32'd0);
    check("areset_valid", 32'(bus.bus_valid), 32'd0);
    bus.req = N'(1);
    #1;
    clear = 1'b1;
    step();
    check_owner("areset_regrant", 0);

    // random invariants
    prev_gnt = bus.gnt;
    for (int c = 0; c < 10000; c++) begin
      bus.req  = N'($urandom & $urandom & $urandom);
      bus.lock = ($urandom_range(0, 3) == 0);
      step();
      check("rnd_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      check("rnd_valid", 32'(bus.bus_valid), 32'(|bus.gnt));
      if (bus.gnt != '0) begin
        check("rnd_sel", 32'(bus.gnt), 32'(1) << bus.bus_sel);
        if (prev_gnt != '0) begin
          check("rnd_turnaround", 32'(bus.gnt), 32'(prev_gnt));
        end
      end else begin
        check("rnd_sel_zero", 32'(bus.bus_sel), 32'd0);
      end
      prev_gnt = bus.gnt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
